// File: rtl/alu_issue_sequencer.sv
// In-order ALU issue sequencer: a small instruction FIFO feeding one
// instruction per cycle to the ALU. An instruction that reads the
// destination of the instruction issued in the previous cycle is held for
// one bubble cycle. Sticky ALU flags and an issue counter are kept alongside.
module alu_issue_sequencer #(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [25:0]              in_instruction,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [25:0]              issue_instruction,
  output logic                     issue_valid,
  input  logic                     alu_overflow,
  input  logic                     alu_c_out,
  input  logic                     clear_flags,
  output logic                     sticky_overflow,
  output logic                     sticky_carry,
  output logic [COUNT_W-1:0]       issued_count,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  state_t         state;
  logic [25:0]    mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [LW-1:0]  level;
  logic           issued_d;

  logic           last_vld;
  logic [3:0]     last_dest;

  logic           push, pop;
  logic [LW-1:0]  level_n;
  logic [AW-1:0]  head_idx;
  logic [25:0]    head_n;
  logic           last_vld_n;
  logic [3:0]     last_dest_n;
  logic           hazard_n;
  state_t         state_n;

  // The presented head is the FIFO head; it leaves the queue at the edge
  // ending its issue cycle. in_ready gives no credit for that pop.
  always_comb begin
    in_ready    = !reset && (level < LW'(DEPTH));
    push        = in_valid && in_ready;
    pop         = issue_valid;
    level_n     = level + LW'(push) - LW'(pop);
    // Head after this edge: next stored entry, or the word being pushed now
    // when nothing older remains.
    head_idx    = rd_ptr + AW'(pop);
    head_n      = (level > LW'(pop)) ? mem[head_idx] : in_instruction;
    // Only an instruction actually issued this cycle can cause a hazard next
    // cycle; NOPs never do, and a bubble cycle clears the dependency.
    last_vld_n  = issue_valid && (issue_instruction[25:22] != 4'b0000);
    last_dest_n = issue_instruction[21:18];
    hazard_n    = last_vld_n && ((head_n[17:14] == last_dest_n) ||
                                 (head_n[13:10] == last_dest_n));
    if (level_n == '0)   state_n = IDLE;
    else if (hazard_n)   state_n = STALL;
    else                 state_n = ISSUE;
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_instruction;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level_n;
    end
  end

  // Issue FSM with registered issue outputs decided one edge ahead.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      issue_valid       <= 1'b0;
      issue_instruction <= '0;
      last_vld          <= 1'b0;
      last_dest         <= '0;
    end else begin
      state             <= state_n;
      issue_valid       <= (state_n == ISSUE);
      issue_instruction <= (state_n == ISSUE) ? head_n : 26'b0;
      last_vld          <= last_vld_n;
      last_dest         <= last_dest_n;
    end
  end

  // Sticky flags sample the ALU in the cycle after an issue; set beats clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      issued_d        <= 1'b0;
      sticky_overflow <= 1'b0;
      sticky_carry    <= 1'b0;
      issued_count    <= '0;
    end else begin
      issued_d <= issue_valid;
      if (issued_d && alu_overflow) sticky_overflow <= 1'b1;
      else if (clear_flags)         sticky_overflow <= 1'b0;
      if (issued_d && alu_c_out)    sticky_carry    <= 1'b1;
      else if (clear_flags)         sticky_carry    <= 1'b0;
      if (issue_valid) issued_count <= issued_count + COUNT_W'(1);
    end
  end

  assign queue_level = level;
  assign busy        = (level != '0) || (state != IDLE);

  // last_vld/last_dest document the dependency held across the edge; the
  // hazard itself is evaluated from the issue registers above.
  logic unused_last;
  assign unused_last = last_vld ^ (^last_dest);

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench: accepted pushes are queued as expected issues; a negedge
// monitor checks every DUT output against a queue-level model of the
// issue/stall rules, flags and counter.
module tb_alu_issue_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [25:0]       in_instruction;
  logic              in_valid;
  logic              in_ready;
  logic [25:0]       issue_instruction;
  logic              issue_valid;
  logic              alu_overflow, alu_c_out, clear_flags;
  logic              sticky_overflow, sticky_carry;
  logic [CW-1:0]     issued_count;
  logic [$clog2(DEPTH):0] queue_level;
  logic              busy;

  alu_issue_sequencer #(.DEPTH(DEPTH), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .in_instruction(in_instruction),
    .in_valid(in_valid), .in_ready(in_ready),
    .issue_instruction(issue_instruction), .issue_valid(issue_valid),
    .alu_overflow(alu_overflow), .alu_c_out(alu_c_out),
    .clear_flags(clear_flags), .sticky_overflow(sticky_overflow),
    .sticky_carry(sticky_carry), .issued_count(issued_count),
    .queue_level(queue_level), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [25:0] pend[$];
  bit          cur_issue = 0;
  bit          last_v = 0;
  logic [25:0] last_i = '0;
  bit          after_issue = 0;
  bit          so = 0, sc = 0;
  int unsigned cnt = 0;
  bit          acc;

  function automatic logic [25:0] mk(input int op, input int d, input int a,
                                     input int b, input int imm);
    logic [25:0] r;
    r = {op[3:0], d[3:0], a[3:0], b[3:0], imm[9:0]};
    return r;
  endfunction

  function automatic bit depends(input logic [25:0] prev, input logic [25:0] h);
    return (prev[25:22] != 4'd0) &&
           ((h[17:14] == prev[21:18]) || (h[13:10] == prev[21:18]));
  endfunction

  // Model advances on every clock edge using the inputs held across it.
  always @(posedge clock) begin
    if (reset) begin
      pend.delete();
      cur_issue = 0; last_v = 0; after_issue = 0; so = 0; sc = 0; cnt = 0;
    end else begin
      acc = in_valid && (pend.size() < DEPTH);
      if (after_issue && alu_overflow) so = 1; else if (clear_flags) so = 0;
      if (after_issue && alu_c_out)    sc = 1; else if (clear_flags) sc = 0;
      last_v = cur_issue;
      if (cur_issue) begin
        last_i = pend.pop_front();
        cnt++;
      end
      after_issue = cur_issue;
      if (acc) pend.push_back(in_instruction);
      cur_issue = (pend.size() > 0) && !(last_v && depends(last_i, pend[0]));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs mid-cycle against the model.
  always @(negedge clock) begin
    chk("issue_valid", {31'd0, issue_valid}, {31'd0, cur_issue});
    if (issue_valid) begin
      if (pend.size() == 0) chk("issue_unexpected", 32'd1, 32'd0);
      else chk("issue_instruction", {6'd0, issue_instruction}, {6'd0, pend[0]});
    end else begin
      chk("idle_instruction_zero", {6'd0, issue_instruction}, 32'd0);
    end
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!reset && pend.size() < DEPTH)});
    chk("queue_level", 32'(queue_level), 32'(pend.size()));
    chk("busy", {31'd0, busy}, {31'd0, (pend.size() != 0)});
    chk("issued_count", 32'(issued_count), cnt % (1 << CW));
    chk("sticky_overflow", {31'd0, sticky_overflow}, {31'd0, so});
    chk("sticky_carry", {31'd0, sticky_carry}, {31'd0, sc});
  end

  task automatic step(input bit v, input logic [25:0] instr);
    @(posedge clock); #1;
    in_valid = v;
    in_instruction = instr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 26'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instruction = '0;
    alu_overflow = 1'b0; alu_c_out = 1'b0; clear_flags = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Three independent instructions back-to-back
    step(1, mk(1, 1, 8, 9, 1));
    step(1, mk(2, 2, 10, 11, 2));
    step(1, mk(3, 3, 12, 13, 3));
    idle(5);

    // Read-after-write hazard, then the same pair with a NOP producer
    step(1, mk(4, 5, 0, 1, 0));
    step(1, mk(4, 6, 5, 1, 0));
    idle(5);
    step(1, mk(0, 5, 0, 1, 0));
    step(1, mk(4, 6, 5, 1, 0));
    idle(5);

    // Dependent chain fills the queue while stalling
    for (int i = 0; i < 9; i++) step(1, mk(1, (i + 1) % 16, i % 16, 15, i));
    idle(20);

    // Carry arrives with a simultaneous clear, then clear alone
    step(1, mk(1, 1, 2, 3, 0));
    step(0, '0);
    #0 begin alu_c_out = 1; clear_flags = 1; end
    step(0, '0); alu_c_out = 0; clear_flags = 1;
    step(0, '0); clear_flags = 0;
    idle(3);

    // Reset while entries are queued
    for (int i = 0; i < 5; i++) step(1, mk(1, (i + 1) % 16, i % 16, 15, i));
    @(posedge clock); #1 reset = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    idle(6);

    // Randomized traffic with occasional resets; counter wraps (CW=8)
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      reset          = ($urandom_range(0, 199) == 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      in_instruction = mk($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 1023));
      alu_overflow   = $urandom_range(0, 1);
      alu_c_out      = $urandom_range(0, 1);
      clear_flags    = ($urandom_range(0, 3) == 0);
    end
    @(posedge clock); #1 reset = 1'b0; in_valid = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
